// File: rtl/bitwise_lane_unit_pkg.sv
// Shared definitions for the lane-serial bitwise unit: op codes, FSM states
// and the slice-index width helper.
package bitwise_lane_unit_pkg;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOT  = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // A single-slice configuration still needs a one-bit index register.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bitwise_slice.sv
// Combinational LANE-wide logic op; the unit time-multiplexes one instance
// across all slices of the operands.
module bitwise_slice
   import bitwise_lane_unit_pkg::*;
#(
   parameter int LANE = 4
) (
   input  logic [LANE-1:0] a,
   input  logic [LANE-1:0] b,
   input  logic [2:0]      op,
   output logic [LANE-1:0] y
);

   always_comb begin
      // NOTE: default first so no op value can leave y unassigned (no latch).
      y = '0;
      case (op_e'(op))
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_NOT:  y = ~a;
         OP_PASS: y = a;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/bitwise_lane_unit.sv
// Multi-cycle bitwise logic unit: captures a request, evaluates LANE bits per
// clock, then holds the result with Hack-style zr/ng flags until consumed.
module bitwise_lane_unit
   import bitwise_lane_unit_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LANE  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zr,
   output logic             ng
);

   localparam int          N    = WIDTH / LANE;
   localparam int          IW   = int'(idx_width(N));
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_e            state, state_nxt;
   logic [WIDTH-1:0]  a_cap, b_cap;
   logic [2:0]        op_cap;
   logic [IW-1:0]     idx;
   logic              nz_acc;
   logic [LANE-1:0]   slice_y;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = ~reset;
            if (in_valid && !reset) state_nxt = S_RUN;
         end
         S_RUN: begin
            if (idx == LAST) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: capture registers carry no reset; they are always loaded at accept before use.
   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         a_cap  <= a;
         b_cap  <= b;
         op_cap <= op;
      end
   end

   bitwise_slice #(
      .LANE (LANE)
   ) u_slice (
      .a  (a_cap[int'(idx)*LANE +: LANE]),
      .b  (b_cap[int'(idx)*LANE +: LANE]),
      .op (op_cap),
      .y  (slice_y)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         out    <= '0;
         idx    <= '0;
         nz_acc <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid && in_ready) begin
                  out    <= '0;
                  idx    <= '0;
                  nz_acc <= 1'b0;
               end
            end
            S_RUN: begin
               out[int'(idx)*LANE +: LANE] <= slice_y;
               nz_acc <= nz_acc | (|slice_y);
               idx    <= (idx == LAST) ? '0 : idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Zero flag is only meaningful while a result is presented.
   assign zr = out_valid & ~nz_acc;
   assign ng = out[WIDTH-1];

endmodule

// File: tb/tb_bitwise_lane_unit.sv
// Scoreboard bench for bitwise_lane_unit: default config plus three parameter
// variants, directed vectors with hand-computed results.
module tb_bitwise_lane_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        out_ready = 1'b1;
   logic [31:0] a = '0, b = '0;
   logic [2:0]  op = '0;
   logic [3:0]  in_valid = '0;

   logic        rdy0, rdy1, rdy2, rdy3;
   logic        ov0, ov1, ov2, ov3;
   logic        zr0, zr1, zr2, zr3;
   logic        ng0, ng1, ng2, ng3;
   logic [15:0] out0, out1, out2;
   logic [31:0] out3;
   logic [3:0]  rdy, ovld, zrv, ngv;

   assign rdy  = {rdy3, rdy2, rdy1, rdy0};
   assign ovld = {ov3, ov2, ov1, ov0};
   assign zrv  = {zr3, zr2, zr1, zr0};
   assign ngv  = {ng3, ng2, ng1, ng0};

   always #5 clk = ~clk;

   bitwise_lane_unit #(.WIDTH(16), .LANE(4)) dut0 (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(rdy0),
      .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(ov0), .out_ready(out_ready),
      .out(out0), .zr(zr0), .ng(ng0));
   bitwise_lane_unit #(.WIDTH(16), .LANE(16)) dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(rdy1),
      .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(ov1), .out_ready(out_ready),
      .out(out1), .zr(zr1), .ng(ng1));
   bitwise_lane_unit #(.WIDTH(16), .LANE(1)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(rdy2),
      .a(a[15:0]), .b(b[15:0]), .op(op), .out_valid(ov2), .out_ready(out_ready),
      .out(out2), .zr(zr2), .ng(ng2));
   bitwise_lane_unit #(.WIDTH(32), .LANE(8)) dut3 (
      .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(rdy3),
      .a(a), .b(b), .op(op), .out_valid(ov3), .out_ready(out_ready),
      .out(out3), .zr(zr3), .ng(ng3));

   typedef struct {
      int          dut;
      logic [31:0] out;
      logic        zr;
      logic        ng;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] out_of(input int d);
      case (d)
         0:       return {16'h0, out0};
         1:       return {16'h0, out1};
         2:       return {16'h0, out2};
         default: return out3;
      endcase
   endfunction

   // Monitor: latency on out_valid rise, result/flags on each output handshake.
   initial begin
      int   cyc = 0;
      int   acc_cyc[4];
      logic prev_v[4];
      exp_t e;
      for (int d = 0; d < 4; d++) begin
         acc_cyc[d] = 0;
         prev_v[d]  = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (in_valid[d] && rdy[d]) acc_cyc[d] = cyc;
            if (ovld[d] === 1'b1 && prev_v[d] !== 1'b1 && exp_q.size() != 0)
               check($sformatf("latency_dut%0d", d), cyc - acc_cyc[d] - 1, exp_q[0].lat);
            if (ovld[d] === 1'b1 && out_ready) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("unexpected_dut%0d", d), 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check($sformatf("dut_id_dut%0d", d), d, e.dut);
                  check($sformatf("out_dut%0d", d), out_of(d), e.out);
                  check($sformatf("zr_dut%0d", d), {31'b0, zrv[d]}, {31'b0, e.zr});
                  check($sformatf("ng_dut%0d", d), {31'b0, ngv[d]}, {31'b0, e.ng});
               end
            end
            prev_v[d] = ovld[d];
         end
         cyc++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic issue(input int d, input logic [31:0] av, input logic [31:0] bv,
                        input logic [2:0] o, input bit push, input logic [31:0] eo,
                        input logic ez, input logic en, input int lat);
      bit ok = 1'b0;
      if (push) exp_q.push_back('{d, eo, ez, en, lat});
      a = av;
      b = bv;
      op = o;
      in_valid[d] = 1'b1;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(negedge clk);
         ok = rdy[d];
         @(posedge clk);
         #2;
      end
      in_valid[d] = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) step(1);
      check("drain", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bit seen;
      step(2);
      @(negedge clk);
      check("in_ready_in_reset", {31'b0, rdy0}, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      check("rst_out", {16'h0, out0}, 0);
      check("rst_zr", {31'b0, zr0}, 0);
      check("rst_ng", {31'b0, ng0}, 0);
      check("rst_out_valid", {31'b0, ov0}, 0);
      check("rst_in_ready", {31'b0, rdy0}, 1);
      @(posedge clk);
      #2;

      // Main ops on the default configuration.
      issue(0, 32'hF0F0, 32'hFF00, 3'd0, 1, 32'hF000, 1'b0, 1'b1, 4);
      issue(0, 32'h1234, 32'h1234, 3'd2, 1, 32'h0000, 1'b1, 1'b0, 4);
      issue(0, 32'hFFFF, 32'hFFFF, 3'd3, 1, 32'h0000, 1'b1, 1'b0, 4);
      issue(0, 32'h0F0F, 32'h00F0, 3'd4, 1, 32'hF000, 1'b0, 1'b1, 4);
      drain();

      // Backpressure: result held, extra request ignored.
      out_ready = 1'b0;
      issue(0, 32'h0001, 32'h8000, 3'd1, 1, 32'h8001, 1'b0, 1'b1, 4);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = ov0;
         @(posedge clk);
         #2;
      end
      check("bp_out_valid_rise", {31'b0, seen}, 1);
      a = 32'h7777;
      in_valid[0] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_out", {16'h0, out0}, 32'h8001);
         check("bp_hold_ng", {31'b0, ng0}, 1);
         check("bp_hold_in_ready", {31'b0, rdy0}, 0);
         @(posedge clk);
         #2;
      end
      in_valid[0] = 1'b0;
      out_ready = 1'b1;
      step(1);
      @(negedge clk);
      check("bp_idle_in_ready", {31'b0, rdy0}, 1);
      check("bp_idle_out_valid", {31'b0, ov0}, 0);
      @(posedge clk);
      #2;
      step(6);
      @(negedge clk);
      check("bp_no_queued_req", {31'b0, ov0}, 0);
      @(posedge clk);
      #2;

      // Reset two slices into a RUN.
      issue(0, 32'hFFFF, 32'hFFFF, 3'd0, 0, 32'h0, 1'b0, 1'b0, 0);
      step(2);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      @(negedge clk);
      check("midrst_out", {16'h0, out0}, 0);
      check("midrst_out_valid", {31'b0, ov0}, 0);
      check("midrst_zr", {31'b0, zr0}, 0);
      check("midrst_in_ready", {31'b0, rdy0}, 1);
      @(posedge clk);
      #2;
      issue(0, 32'hAAAA, 32'h5555, 3'd5, 1, 32'h0000, 1'b1, 1'b0, 4);
      drain();

      // Operand change after accept must not affect the result.
      issue(0, 32'h00FF, 32'h0000, 3'd6, 1, 32'hFF00, 1'b0, 1'b1, 4);
      a = 32'h1111;
      drain();

      // Parameter variants.
      issue(1, 32'hF0F0, 32'hFF00, 3'd0, 1, 32'hF000, 1'b0, 1'b1, 1);
      drain();
      issue(2, 32'h1234, 32'h00FF, 3'd2, 1, 32'h12CB, 1'b0, 1'b0, 16);
      drain();
      issue(3, 32'hDEADBEEF, 32'h0, 3'd7, 1, 32'hDEADBEEF, 1'b0, 1'b1, 4);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
